// File: rtl/ntt_pkg.sv
// Shared NTT constants, Barrett reduction constant and twiddle-generator state type.
// Imported by twiddle_gen, its interface and the mod_mul datapath.
package ntt_pkg;

    localparam int DATA_SIZE = 13;
    localparam int RING_SIZE = 256;
    localparam int LOG_N     = $clog2(RING_SIZE);
    localparam int HALF_N    = RING_SIZE / 2;

    localparam logic [DATA_SIZE-1:0] Q = 13'h1e01;

    // floor(2^(2*DATA_SIZE) / Q); one bit wider than a coefficient
    localparam int BARRETT_K = 2 * DATA_SIZE;
    localparam int MU_W      = DATA_SIZE + 1;
    localparam logic [MU_W-1:0] BARRETT_MU = MU_W'((64'd1 << BARRETT_K) / 64'(Q));

    // First stage index that is out of range for an N-point transform
    localparam logic [LOG_N-1:0] STAGE_LIMIT = LOG_N'(LOG_N);
    // Handshake count of the final twiddle in a stage
    localparam logic [LOG_N-1:0] CNT_LAST    = LOG_N'(HALF_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    // Any DATA_SIZE-bit value is below 2*Q, so one subtract fully reduces it
    function automatic logic [DATA_SIZE-1:0] reduce_once(input logic [DATA_SIZE-1:0] x);
        return (x >= Q) ? (x - Q) : x;
    endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Request/stream bundle between a stage sequencer and twiddle_gen.
// Inverse-root ports exist only when TWIDDLE_GEN_INV_EN is defined.
interface twiddle_gen_if;
    import ntt_pkg::*;

    logic                 start;
    logic [LOG_N-1:0]     stage_i;
    logic [DATA_SIZE-1:0] omega_i;
`ifdef TWIDDLE_GEN_INV_EN
    logic                 inverse_i;
    logic [DATA_SIZE-1:0] omega_inv_i;
`endif
    logic                 ready_i;
    logic [DATA_SIZE-1:0] twiddle_o;
    logic                 valid_o;
    logic                 busy_o;
    logic                 done_o;

    // Sequencer / consumer side
    modport master (
        output start, stage_i, omega_i, ready_i,
`ifdef TWIDDLE_GEN_INV_EN
        output inverse_i, omega_inv_i,
`endif
        input  twiddle_o, valid_o, busy_o, done_o
    );

    // Generator side
    modport slave (
        input  start, stage_i, omega_i, ready_i,
`ifdef TWIDDLE_GEN_INV_EN
        input  inverse_i, omega_inv_i,
`endif
        output twiddle_o, valid_o, busy_o, done_o
    );

endinterface

// File: rtl/mod_mul.sv
// Combinational a*b mod Q via Barrett reduction. Operands must already be < Q;
// then the Barrett remainder is < 2Q and a single conditional subtract finishes.
module mod_mul
    import ntt_pkg::*;
(
    input  logic [DATA_SIZE-1:0] a_i,
    input  logic [DATA_SIZE-1:0] b_i,
    output logic [DATA_SIZE-1:0] p_o
);

    localparam int PW = 2 * DATA_SIZE;
    localparam int XW = PW + MU_W;
    localparam int RW = DATA_SIZE + 1;

    logic [PW-1:0] prod;
    logic [RW-1:0] qhat;
    logic [PW-1:0] qq;
    logic [RW-1:0] rem;

    // product, quotient estimate, remainder and final correction
    always_comb begin
        prod = PW'(a_i) * PW'(b_i);
        qhat = RW'((XW'(prod) * XW'(BARRETT_MU)) >> BARRETT_K);
        qq   = PW'(qhat) * PW'(Q);
        rem  = RW'(prod - qq);
        if (rem >= RW'(Q)) begin
            rem = rem - RW'(Q);
        end
        p_o = rem[DATA_SIZE-1:0];
    end

endmodule

// File: rtl/twiddle_gen.sv
// Streams omega^j mod Q for one radix-2 NTT stage: j = 0..m-1 inner, groups outer,
// N/2 values per run, one modular multiply per output.
// Optional inverse-root selection is compiled in with `define TWIDDLE_GEN_INV_EN.
module twiddle_gen
    import ntt_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    twiddle_gen_if.slave  bus
);

    state_e               state_q, state_d;
    logic [LOG_N-1:0]     stage_q, stage_d;
    logic [DATA_SIZE-1:0] omega_q, omega_d;
    logic [DATA_SIZE-1:0] tw_q, tw_d;
    logic [LOG_N-1:0]     j_q, j_d;
    logic [LOG_N-1:0]     cnt_q, cnt_d;

    logic [DATA_SIZE-1:0] omega_sel;
    logic [DATA_SIZE-1:0] tw_next;
    logic [LOG_N-1:0]     j_last;
    logic                 accept;
    logic                 hs;

    mod_mul u_mod_mul (
        .a_i (tw_q),
        .b_i (omega_q),
        .p_o (tw_next)
    );

    // start acceptance, handshake and root selection
    always_comb begin
`ifdef TWIDDLE_GEN_INV_EN
        omega_sel = bus.inverse_i ? bus.omega_inv_i : bus.omega_i;
`else
        omega_sel = bus.omega_i;
`endif
        accept = (state_q == ST_IDLE) && bus.start && (bus.stage_i < STAGE_LIMIT);
        hs     = (state_q == ST_RUN) && bus.ready_i;
        j_last = LOG_N'((32'd1 << stage_q) - 32'd1);
    end

    // state register and datapath flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            omega_q <= '0;
            tw_q    <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            omega_q <= omega_d;
            tw_q    <= tw_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: IDLE -> RUN on accepted start, RUN -> FIN on last handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (hs && (cnt_q == CNT_LAST)) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // latch stage parameters on start; step the power on each handshake
    always_comb begin
        stage_d = stage_q;
        omega_d = omega_q;
        tw_d    = tw_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        if (accept) begin
            stage_d = bus.stage_i;
            omega_d = reduce_once(omega_sel);
            tw_d    = DATA_SIZE'(1);
            j_d     = '0;
            cnt_d   = '0;
        end else if (hs) begin
            cnt_d = cnt_q + 1'b1;
            // wrap to omega^0 at each group boundary rather than multiplying on
            if (j_q == j_last) begin
                j_d  = '0;
                tw_d = DATA_SIZE'(1);
            end else begin
                j_d  = j_q + 1'b1;
                tw_d = tw_next;
            end
        end
    end

    // Moore outputs decoded from state
    always_comb begin
        bus.valid_o   = (state_q == ST_RUN);
        bus.busy_o    = (state_q == ST_RUN);
        bus.done_o    = (state_q == ST_FIN);
        bus.twiddle_o = tw_q;
    end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: expected twiddles are queued at start and
// popped by a negedge monitor on every valid/ready handshake.
module tb_twiddle_gen;
    import ntt_pkg::*;

    localparam longint MODQ = 7681;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    twiddle_gen_if bus();

    twiddle_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    logic [12:0] exp_q[$];
    logic        stall_q = 1'b0;
    logic [12:0] stall_tw = '0;

    // reference sequence: omega^j mod Q, j inner, groups outer
    function automatic void push_stage(input int stage, input int omega);
        longint w, pw;
        int m;
        w  = longint'(omega) % MODQ;
        m  = 1 << stage;
        pw = 1;
        for (int g = 0; g < 128 / m; g++) begin
            for (int j = 0; j < m; j++) begin
                pw = (j == 0) ? 64'd1 : (pw * w) % MODQ;
                exp_q.push_back(pw[12:0]);
            end
        end
    endfunction

    // monitor: stall hold check and scoreboard pop on each handshake
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (stall_q) begin
                n_tests++;
                if (bus.valid_o !== 1'b1 || bus.twiddle_o !== stall_tw) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b twiddle=%0d, required valid=1 twiddle=%0d",
                             bus.valid_o, bus.twiddle_o, stall_tw);
                end
            end
            if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
                n_tests++;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: twiddle=%0d at handshake %0d, nothing expected",
                             bus.twiddle_o, hs_cnt);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    if (bus.twiddle_o !== e) begin
                        n_fail++;
                        $display("FAIL sb_value: handshake %0d twiddle=%0d, required %0d",
                                 hs_cnt, bus.twiddle_o, e);
                    end
                end
            end
            stall_q  = (bus.valid_o === 1'b1) && (bus.ready_i !== 1'b1);
            stall_tw = bus.twiddle_o;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic do_start(input int stage, input int omega, input bit expect_accept);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.stage_i = 8'(stage);
        bus.omega_i = 13'(omega);
        if (expect_accept) begin
            hs_cnt = 0;
            push_stage(stage, omega);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // drive ready until done_o is seen at a negedge (bounded); optionally
    // raise start during the FIN cycle
    task automatic run_to_done(input bit rand_ready, input bit fin_start, output bit got_done);
        got_done = 1'b0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                got_done = 1'b1;
                if (fin_start) begin
                    bus.start   = 1'b1;
                    bus.stage_i = 8'd2;
                    bus.omega_i = 13'd3;
                end
            end else begin
                @(posedge clk); #1;
                bus.ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.valid_o, bus.busy_o, bus.done_o, bus.twiddle_o} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b busy=%b done=%b twiddle=%0d, required all 0",
                     bus.valid_o, bus.busy_o, bus.done_o, bus.twiddle_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // stage 2, omega 3: latency, done timing, and start during FIN ignored
    task automatic test_stage2_omega3;
        bit got;
        bus.ready_i = 1'b1;
        do_start(2, 3, 1'b1);
        n_tests++;
        if (bus.valid_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.twiddle_o !== 13'd1) begin
            n_fail++;
            $display("FAIL start_latency: valid=%b busy=%b twiddle=%0d, required 1 1 1",
                     bus.valid_o, bus.busy_o, bus.twiddle_o);
        end
        run_to_done(1'b0, 1'b1, got);
        n_tests++;
        if (!got || bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0 || hs_cnt != 128 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL s2w3_end: done=%b busy=%b valid=%b hs=%0d left=%0d, required 1 0 0 128 0",
                     got, bus.busy_o, bus.valid_o, hs_cnt, exp_q.size());
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (bus.done_o !== 1'b0 || bus.valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL done_pulse_fin_start: done=%b valid=%b, required 0 0",
                         bus.done_o, bus.valid_o);
            end
        end
    endtask

    // full reduction: 4000^2 wraps mod Q, and an omega above Q is reduced at latch
    task automatic test_full_reduction;
        bit got;
        int om [2] = '{4000, 8000};
        int st [2] = '{2, 1};
        bus.ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_start(st[k], om[k], 1'b1);
            run_to_done(1'b0, 1'b0, got);
            n_tests++;
            if (!got || hs_cnt != 128 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL reduction_end omega=%0d: done=%b hs=%0d left=%0d, required 1 128 0",
                         om[k], got, hs_cnt, exp_q.size());
            end
        end
    endtask

    // smallest spans: alternating 1/Q-1 and the all-ones stage 0
    task automatic test_small_stages;
        bit got;
        int om [2] = '{7680, 1234};
        int st [2] = '{1, 0};
        bus.ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_start(st[k], om[k], 1'b1);
            run_to_done(1'b0, 1'b0, got);
            n_tests++;
            if (!got || hs_cnt != 128 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL small_stage_end s=%0d: done=%b hs=%0d left=%0d, required 1 128 0",
                         st[k], got, hs_cnt, exp_q.size());
            end
        end
    endtask

    task automatic test_backpressure;
        bit got;
        bus.ready_i = 1'b0;
        do_start(3, 1000, 1'b1);
        run_to_done(1'b1, 1'b0, got);
        n_tests++;
        if (!got || hs_cnt != 128 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL backpressure_end: done=%b hs=%0d left=%0d, required 1 128 0",
                     got, hs_cnt, exp_q.size());
        end
        bus.ready_i = 1'b1;
    endtask

    task automatic test_ignored_starts;
        bit got;
        bus.ready_i = 1'b1;
        do_start(2, 3, 1'b1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.start   = 1'b1;
        bus.stage_i = 8'd1;
        bus.omega_i = 13'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        run_to_done(1'b0, 1'b0, got);
        n_tests++;
        if (!got || hs_cnt != 128 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start_end: done=%b hs=%0d left=%0d, required 1 128 0",
                     got, hs_cnt, exp_q.size());
        end
        do_start(8, 3, 1'b0);
        repeat (5) begin
            @(negedge clk);
            n_tests++;
            if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stage8_ignored: valid=%b busy=%b, required 0 0",
                         bus.valid_o, bus.busy_o);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        bit got;
        bus.ready_i = 1'b1;
        do_start(2, 3, 1'b1);
        for (int c = 0; c < 300 && hs_cnt < 50; c++) begin
            @(posedge clk); #1;
        end
        n_tests++;
        if (hs_cnt != 50) begin
            n_fail++;
            $display("FAIL reach_hs50: hs=%0d, required 50", hs_cnt);
        end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({bus.valid_o, bus.busy_o, bus.done_o, bus.twiddle_o} !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: valid=%b busy=%b done=%b twiddle=%0d, required all 0",
                     bus.valid_o, bus.busy_o, bus.done_o, bus.twiddle_o);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (bus.done_o !== 1'b0 || bus.valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: done=%b valid=%b, required 0 0",
                         bus.done_o, bus.valid_o);
            end
        end
        do_start(1, 7680, 1'b1);
        run_to_done(1'b0, 1'b0, got);
        n_tests++;
        if (!got || hs_cnt != 128 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_end: done=%b hs=%0d left=%0d, required 1 128 0",
                     got, hs_cnt, exp_q.size());
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.stage_i = '0;
        bus.omega_i = '0;
        bus.ready_i = 1'b0;
`ifdef TWIDDLE_GEN_INV_EN
        bus.inverse_i   = 1'b0;
        bus.omega_inv_i = '0;
`endif
        test_reset();
        test_stage2_omega3();
        test_full_reduction();
        test_small_stages();
        test_backpressure();
        test_ignored_starts();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Streams twiddle factors to the PE butterfly datapath (feeds PE twiddle_i) for one radix-2 NTT stage per run.
- Stage s has span m = 2^s. It emits RING_SIZE/2 twiddles ordered j = 0..m-1 inner and group g outer; each value is omega^j mod Q.
- Values are generated iteratively with one modular multiply per output, so no ROM is needed.

Parameters:
- DATA_SIZE, 13, coefficient/twiddle width (matches DATA_SIZE_ARB).
- RING_SIZE, 256, NTT length N (power of two).
- Q, 7681, modulus (13'h1e01).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a stage
- stage_i  in  $clog2(RING_SIZE)  stage index s, sampled on accepted start
- omega_i  in  DATA_SIZE  stage root (primitive 2^(s+1)-th root), sampled on accepted start
- ready_i  in  1  consumer accepts twiddle_o this cycle
- twiddle_o  out  DATA_SIZE  current twiddle
- valid_o  out  1  twiddle_o is valid
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse after the last twiddle is accepted

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately; no done_o pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - start && stage_i < log2(N): latch stage, omega, m = 1<<stage; set twiddle_o = 1, j = 0, cnt = 0; go to RUN.
  - start with stage_i >= log2(N) is ignored.
- Latency: start at edge t gives valid_o = 1, busy_o = 1 and twiddle_o = 1 visible after edge t.
- RUN:
  - valid_o = 1.
  - Handshake fires when valid_o && ready_i.
  - On handshake: if j == m-1 then j = 0 and twiddle_o = 1; else j++ and twiddle_o = mod_mul(twiddle_o, omega).
  - cnt++ on every handshake.
  - Handshake with cnt == N/2-1: go to FIN, valid_o = 0.
- Backpressure: ready_i = 0 holds twiddle_o, j and cnt stable. valid_o never drops while in RUN.
- FIN: done_o = 1 for exactly one cycle, busy_o = 0, return to IDLE. A start arriving in FIN is ignored.
- start while busy_o is ignored; latched stage and omega are unaffected.
- Stage 0 (m = 1): every output is 1 and omega is never used.
- Arithmetic:
  - Product is 2*DATA_SIZE bits, fully reduced to [0, Q-1].
  - omega_i >= Q is reduced once at latch time.
  - The block does not check the root property of omega.

Optional Feature:
- Macro TWIDDLE_GEN_INV_EN enables inverse-NTT support.
- With it: adds ports inverse_i (in, 1) and omega_inv_i (in, DATA_SIZE). When inverse_i = 1 at an accepted start, omega_inv_i is latched in place of omega_i. Ordering and handshake are unchanged.
- Without it: those ports are absent and the forward root is always used.

Decomposition:
- Package ntt_pkg holds:
  - DATA_SIZE, RING_SIZE, LOG_N, Q
  - Barrett constant floor(2^(2*DATA_SIZE)/Q)
  - state enum type
- Sub-module mod_mul: combinational a*b mod Q using Barrett reduction with one conditional subtract. It is reused later by PE.

Test Plan:
- stage 2, omega 3, ready held 1 -> twiddle_o sequence 1,3,9,27 repeated 32 times (128 values), then done_o pulse one cycle after last handshake, busy_o low.
- stage 2, omega 4000 -> 1,4000,477,3112 repeating; checks the full reduction mod 7681.
- stage 1, omega 7680 -> 1,7680 alternating ×64; stage 0, any omega -> 128 ones.
- Random ready_i toggling at stage 3 -> twiddle_o held while ready_i = 0; no value skipped or duplicated; exactly 128 handshakes.
- start pulsed mid-run with a different omega -> ignored; original sequence continues. start with stage_i = 8 in IDLE -> no response.
- reset asserted at handshake 50 -> next cycle all outputs 0 with no done_o; a new start then yields a fresh sequence from 1.
